reorder_buffer: RTL and testbench

REORDER_BUFFER -- requirements
Module: reorder_buffer

---
 rtl/reorder_buffer_pkg.sv | 19 +
 rtl/reorder_buffer.sv | 140 ++++++++++++++
 tb/tb_reorder_buffer.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/reorder_buffer_pkg.sv
// Shared types for the reorder buffer: pointer/register widths and the ROB entry payload.
package reorder_buffer_pkg;

  localparam int unsigned ROB_ADDR_W    = 2;
  localparam int unsigned PHY_RF_ADDR_W = 6;
  localparam int unsigned PHY_RF_DATA_W = 32;

  typedef logic [ROB_ADDR_W-1:0]    rob_addr_t;
  typedef logic [PHY_RF_ADDR_W-1:0] phy_rf_addr_t;
  typedef logic [PHY_RF_DATA_W-1:0] phy_rf_data_t;

  typedef struct packed {
    logic         valid;
    logic         done;
    phy_rf_addr_t dest;
    phy_rf_data_t value;
  } rob_entry_t;

endpackage

// File: rtl/reorder_buffer.sv
// In-order commit reorder buffer: tail allocation, out-of-order completion, one commit per cycle.
// Optional macro ROB_COMMIT_BYPASS_EN lets a completion to the head commit at the same edge.
module reorder_buffer
  import reorder_buffer_pkg::*;
#(
  parameter int unsigned ROB_DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         rob_incr_tail_ptr,
  input  phy_rf_addr_t rob_alloc_dest,
  input  logic         res_st_retire_en,
  input  rob_addr_t    res_st_retire_rob_addr,
  input  phy_rf_data_t res_st_retire_value,
  input  logic         flush,
  output rob_addr_t    rob_tail_ptr,
  output logic         rob_full,
  output logic         rob_empty,
  output logic         phy_rf_wr_en,
  output phy_rf_addr_t phy_rf_wr_addr,
  output phy_rf_data_t phy_rf_wr_data,
  output logic         busy_table_wr_en,
  output phy_rf_addr_t busy_table_wr_addr,
  output logic         busy_table_wr_data
);

  localparam int unsigned CNT_W = ROB_ADDR_W + 1;

  rob_entry_t       rob_q [ROB_DEPTH];
  rob_entry_t       rob_d [ROB_DEPTH];
  rob_addr_t        head_q, head_d;
  rob_addr_t        tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic             wr_en_q, wr_en_d;
  phy_rf_addr_t     wr_addr_q, wr_addr_d;
  phy_rf_data_t     wr_data_q, wr_data_d;

  rob_entry_t       head_entry;
  logic             do_commit;
  logic             do_alloc;
  phy_rf_data_t     commit_data;

  assign rob_full  = (count_q == CNT_W'(ROB_DEPTH));
  assign rob_empty = (count_q == '0);
  assign rob_tail_ptr = tail_q;

  assign phy_rf_wr_en       = wr_en_q;
  assign phy_rf_wr_addr     = wr_addr_q;
  assign phy_rf_wr_data     = wr_data_q;
  assign busy_table_wr_en   = wr_en_q;
  assign busy_table_wr_addr = wr_addr_q;
  assign busy_table_wr_data = 1'b0;

  // Next-state: completion, in-order commit, allocation, then flush overrides everything.
  always_comb begin
    rob_d       = rob_q;
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q;
    wr_en_d     = 1'b0;
    wr_addr_d   = '0;
    wr_data_d   = '0;
    head_entry  = rob_q[head_q];
    do_commit   = head_entry.valid && head_entry.done;
    commit_data = head_entry.value;
    do_alloc    = rob_incr_tail_ptr && !rob_full;

`ifdef ROB_COMMIT_BYPASS_EN
    if (!do_commit && res_st_retire_en && head_entry.valid &&
        (res_st_retire_rob_addr == head_q)) begin
      do_commit   = 1'b1;
      commit_data = res_st_retire_value;
    end
`endif

    if (res_st_retire_en && rob_q[res_st_retire_rob_addr].valid) begin
      rob_d[res_st_retire_rob_addr].done  = 1'b1;
      rob_d[res_st_retire_rob_addr].value = res_st_retire_value;
    end

    if (do_commit) begin
      rob_d[head_q].valid = 1'b0;
      rob_d[head_q].done  = 1'b0;
      head_d              = head_q + rob_addr_t'(1);
      wr_en_d             = 1'b1;
      wr_addr_d           = head_entry.dest;
      wr_data_d           = commit_data;
    end

    // Full blocks allocation even when the head frees up at this edge.
    if (do_alloc) begin
      rob_d[tail_q].valid = 1'b1;
      rob_d[tail_q].done  = 1'b0;
      rob_d[tail_q].dest  = rob_alloc_dest;
      rob_d[tail_q].value = '0;
      tail_d              = tail_q + rob_addr_t'(1);
    end

    count_d = count_q + CNT_W'(do_alloc) - CNT_W'(do_commit);

    if (flush) begin
      for (int i = 0; i < ROB_DEPTH; i++) begin
        rob_d[i].valid = 1'b0;
        rob_d[i].done  = 1'b0;
      end
      head_d    = '0;
      tail_d    = '0;
      count_d   = '0;
      wr_en_d   = 1'b0;
      wr_addr_d = '0;
      wr_data_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ROB_DEPTH; i++) begin
        rob_q[i] <= '0;
      end
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      for (int i = 0; i < ROB_DEPTH; i++) begin
        rob_q[i] <= rob_d[i];
      end
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Bench for reorder_buffer: per-cycle vector table plus a commit scoreboard; honours ROB_COMMIT_BYPASS_EN.
module tb_reorder_buffer;
  import reorder_buffer_pkg::*;

`ifdef ROB_COMMIT_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  localparam int NV = 25;

  logic         clk = 1'b0;
  logic         rst;
  logic         rob_incr_tail_ptr;
  phy_rf_addr_t rob_alloc_dest;
  logic         res_st_retire_en;
  rob_addr_t    res_st_retire_rob_addr;
  phy_rf_data_t res_st_retire_value;
  logic         flush;
  rob_addr_t    rob_tail_ptr;
  logic         rob_full;
  logic         rob_empty;
  logic         phy_rf_wr_en;
  phy_rf_addr_t phy_rf_wr_addr;
  phy_rf_data_t phy_rf_wr_data;
  logic         busy_table_wr_en;
  phy_rf_addr_t busy_table_wr_addr;
  logic         busy_table_wr_data;

  reorder_buffer #(.ROB_DEPTH(4)) dut (
    .clk                    (clk),
    .rst                    (rst),
    .rob_incr_tail_ptr      (rob_incr_tail_ptr),
    .rob_alloc_dest         (rob_alloc_dest),
    .res_st_retire_en       (res_st_retire_en),
    .res_st_retire_rob_addr (res_st_retire_rob_addr),
    .res_st_retire_value    (res_st_retire_value),
    .flush                  (flush),
    .rob_tail_ptr           (rob_tail_ptr),
    .rob_full               (rob_full),
    .rob_empty              (rob_empty),
    .phy_rf_wr_en           (phy_rf_wr_en),
    .phy_rf_wr_addr         (phy_rf_wr_addr),
    .phy_rf_wr_data         (phy_rf_wr_data),
    .busy_table_wr_en       (busy_table_wr_en),
    .busy_table_wr_addr     (busy_table_wr_addr),
    .busy_table_wr_data     (busy_table_wr_data)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic         alloc;
    phy_rf_addr_t dest;
    logic         ret_en;
    rob_addr_t    ret_addr;
    phy_rf_data_t ret_val;
    logic         fl;
    logic         exp_full;
    logic         exp_empty;
    rob_addr_t    exp_tail;
    logic         exp_wr;
    phy_rf_addr_t exp_addr;
    phy_rf_data_t exp_data;
  } vec_t;

  typedef struct {
    phy_rf_addr_t a;
    phy_rf_data_t d;
  } sb_t;

  vec_t vecs [NV];
  sb_t  exp_q [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic a, input int d, input logic re, input int ra,
                              input int rv, input logic fl, input logic f, input logic e,
                              input int t, input logic w, input int wa, input int wd);
    vec_t v;
    v.alloc     = a;
    v.dest      = phy_rf_addr_t'(d);
    v.ret_en    = re;
    v.ret_addr  = rob_addr_t'(ra);
    v.ret_val   = phy_rf_data_t'(rv);
    v.fl        = fl;
    v.exp_full  = f;
    v.exp_empty = e;
    v.exp_tail  = rob_addr_t'(t);
    v.exp_wr    = w;
    v.exp_addr  = phy_rf_addr_t'(wa);
    v.exp_data  = phy_rf_data_t'(wd);
    return v;
  endfunction

  task automatic drive(input logic a, input phy_rf_addr_t d, input logic re,
                       input rob_addr_t ra, input phy_rf_data_t rv, input logic fl);
    rob_incr_tail_ptr      = a;
    rob_alloc_dest         = d;
    res_st_retire_en       = re;
    res_st_retire_rob_addr = ra;
    res_st_retire_value    = rv;
    flush                  = fl;
  endtask

  // Scoreboard: every commit pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    sb_t e;
    if (phy_rf_wr_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL sb_unexpected: commit addr %0d data %0d with nothing expected",
                 phy_rf_wr_addr, phy_rf_wr_data);
      end else begin
        e = exp_q.pop_front();
        chk("sb_wr_addr",   32'(phy_rf_wr_addr), 32'(e.a));
        chk("sb_wr_data",   phy_rf_wr_data, e.d);
        chk("sb_busy_en",   32'(busy_table_wr_en), 32'd1);
        chk("sb_busy_addr", 32'(busy_table_wr_addr), 32'(e.a));
        chk("sb_busy_data", 32'(busy_table_wr_data), 32'd0);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  initial begin
    vecs[0]  = mk(1, 4, 0, 0, 0, 0,   0, 0, 1, 0, 0, 0);
    vecs[1]  = mk(1, 5, 0, 0, 0, 0,   0, 0, 2, 0, 0, 0);
    vecs[2]  = mk(1, 6, 0, 0, 0, 0,   0, 0, 3, 0, 0, 0);
    vecs[3]  = mk(1, 7, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0);
    vecs[4]  = mk(0, 0, 1, 2, 63, 0,  1, 0, 0, 0, 0, 0);
    vecs[5]  = mk(0, 0, 1, 0, 23, 0,  !BYP, 0, 0, BYP, 4, 23);
    vecs[6]  = mk(0, 0, 0, 0, 0, 0,   0, 0, 0, !BYP, 4, 23);
    vecs[7]  = mk(0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0);
    vecs[8]  = mk(0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0);
    vecs[9]  = mk(0, 0, 1, 1, 43, 0,  0, 0, 0, BYP, 5, 43);
    vecs[10] = mk(0, 0, 0, 0, 0, 0,   0, 0, 0, 1, BYP ? 6 : 5, BYP ? 63 : 43);
    vecs[11] = mk(0, 0, 0, 0, 0, 0,   0, 0, 0, !BYP, 6, 63);
    vecs[12] = mk(0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0);
    vecs[13] = mk(1, 8, 0, 0, 0, 0,   0, 0, 1, 0, 0, 0);
    vecs[14] = mk(1, 9, 0, 0, 0, 0,   0, 0, 2, 0, 0, 0);
    vecs[15] = mk(1, 10, 0, 0, 0, 0,  1, 0, 3, 0, 0, 0);
    vecs[16] = mk(1, 11, 1, 3, 77, 0, !BYP, 0, 3, BYP, 7, 77);
    vecs[17] = mk(!BYP, 11, 0, 0, 0, 0, 0, 0, 3, !BYP, 7, 77);
    vecs[18] = mk(0, 0, 1, 3, 99, 0,  0, 0, 3, 0, 0, 0);
    vecs[19] = mk(1, 12, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0);
    vecs[20] = mk(0, 0, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0);
    vecs[21] = mk(0, 0, 1, 0, 88, 0,  !BYP, 0, 0, BYP, 8, 88);
    vecs[22] = mk(0, 0, 0, 0, 0, 0,   0, 0, 0, !BYP, 8, 88);
    vecs[23] = mk(1, 13, 1, 1, 5, 1,  0, 1, 0, 0, 0, 0);
    vecs[24] = mk(0, 0, 0, 0, 0, 0,   0, 1, 0, 0, 0, 0);

    rst = 1'b1;
    drive(0, '0, 0, '0, '0, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_full",       32'(rob_full), 32'd0);
    chk("rst_empty",      32'(rob_empty), 32'd1);
    chk("rst_tail",       32'(rob_tail_ptr), 32'd0);
    chk("rst_wr_en",      32'(phy_rf_wr_en), 32'd0);
    chk("rst_wr_addr",    32'(phy_rf_wr_addr), 32'd0);
    chk("rst_wr_data",    phy_rf_wr_data, 32'd0);
    chk("rst_busy_en",    32'(busy_table_wr_en), 32'd0);
    chk("rst_busy_addr",  32'(busy_table_wr_addr), 32'd0);
    chk("rst_busy_data",  32'(busy_table_wr_data), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].alloc, vecs[i].dest, vecs[i].ret_en, vecs[i].ret_addr,
            vecs[i].ret_val, vecs[i].fl);
      if (vecs[i].exp_wr) exp_q.push_back('{a: vecs[i].exp_addr, d: vecs[i].exp_data});
      @(posedge clk);
      #1;
      chk($sformatf("row%0d_full", i),    32'(rob_full), 32'(vecs[i].exp_full));
      chk($sformatf("row%0d_empty", i),   32'(rob_empty), 32'(vecs[i].exp_empty));
      chk($sformatf("row%0d_tail", i),    32'(rob_tail_ptr), 32'(vecs[i].exp_tail));
      chk($sformatf("row%0d_wr_en", i),   32'(phy_rf_wr_en), 32'(vecs[i].exp_wr));
      chk($sformatf("row%0d_busy_en", i), 32'(busy_table_wr_en), 32'(vecs[i].exp_wr));
    end

    // Async reset arriving mid-cycle while a commit pulse and a live entry are present.
    drive(1, 6'd20, 0, '0, '0, 0);
    @(posedge clk); #1;
    drive(1, 6'd21, 0, '0, '0, 0);
    @(posedge clk); #1;
    drive(0, '0, 1, 2'd0, 32'd200, 0);
    exp_q.push_back('{a: 6'd20, d: 32'd200});
    @(posedge clk); #1;
    drive(0, '0, 0, '0, '0, 0);
    for (int i = 0; i < 4 && phy_rf_wr_en !== 1'b1; i++) begin
      @(posedge clk); #1;
    end
    chk("hs_commit_seen",    32'(phy_rf_wr_en), 32'd1);
    chk("hs_pre_rst_empty",  32'(rob_empty), 32'd0);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("hs_arst_empty",     32'(rob_empty), 32'd1);
    chk("hs_arst_full",      32'(rob_full), 32'd0);
    chk("hs_arst_tail",      32'(rob_tail_ptr), 32'd0);
    chk("hs_arst_wr_en",     32'(phy_rf_wr_en), 32'd0);
    chk("hs_arst_busy_en",   32'(busy_table_wr_en), 32'd0);
    chk("hs_arst_wr_data",   phy_rf_wr_data, 32'd0);
    @(posedge clk); #1;
    chk("hs_rst_hold_empty", 32'(rob_empty), 32'd1);
    rst = 1'b0;

    drive(1, 6'd30, 0, '0, '0, 0);
    @(posedge clk); #1;
    chk("hs_post_rst_tail",  32'(rob_tail_ptr), 32'd1);
    chk("hs_post_rst_empty", 32'(rob_empty), 32'd0);
    drive(0, '0, 0, '0, '0, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
